// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - refresh/draw handshake and status bundle for frame_scheduler
interface frame_scheduler_if #(
  parameter int DROP_W = 8
);
  logic              refresh;
  logic              draw_done;
  logic              active_frame;
  logic              draw_start;
  logic              swap;
  logic              move_tick;
  logic              busy;
  logic [DROP_W-1:0] drop_count;
  logic              timeout_err;

  modport master (
    output refresh, draw_done,
    input  active_frame, draw_start, swap, move_tick, busy, drop_count, timeout_err
  );

  modport slave (
    input  refresh, draw_done,
    output active_frame, draw_start, swap, move_tick, busy, drop_count, timeout_err
  );
endinterface

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - double-buffer draw/swap scheduler; FRAME_SCHED_TIMEOUT_EN adds a draw watchdog
module frame_scheduler #(
  parameter int MOVE_DIV       = 2,
  parameter int DROP_W         = 8,
  parameter int TIMEOUT_CYCLES = 420000
) (
  input logic              clk,
  input logic              rst,
  frame_scheduler_if.slave sched
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef enum logic [1:0] {START, DRAW, HOLD} state_e;

  state_e            state_q;
  logic              active_q;
  logic              draw_start_q;
  logic              swap_q;
  logic              move_tick_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;
  logic [CNT_W-1:0]  swap_cnt_q;

  logic done_d;
  logic swap_d;
  logic drop_inc_d;
  logic timeout_hit_d;

  // draw_done is only honoured in DRAW, and not in the cycle the command is still out
  assign done_d = (state_q == DRAW) && !draw_start_q && sched.draw_done;
  assign swap_d = sched.refresh &&
                  (done_d || ((state_q == HOLD) && !swap_q));
  assign drop_inc_d = (state_q == DRAW) && !done_d && (sched.refresh || timeout_hit_d);

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;

  assign timeout_hit_d = (state_q == DRAW) && !done_d &&
                         (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        timer_q <= '0;
      end else if (state_q == DRAW) begin
        timer_q <= timer_q + TMR_W'(1);
      end
      if (timeout_hit_d) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign sched.timeout_err = timeout_q;
`else
  assign timeout_hit_d     = 1'b0;
  assign sched.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= START;
      active_q     <= 1'b0;
      draw_start_q <= 1'b0;
      swap_q       <= 1'b0;
      move_tick_q  <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
      swap_cnt_q   <= '0;
    end else begin
      draw_start_q <= 1'b0;
      swap_q       <= 1'b0;
      move_tick_q  <= 1'b0;

      case (state_q)
        START: begin
          state_q      <= DRAW;
          draw_start_q <= 1'b1;
          busy_q       <= 1'b1;
        end
        DRAW: begin
          if (done_d) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
          end else if (timeout_hit_d) begin
            state_q <= START;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          // the swap cycle itself stays in HOLD so the next command trails swap by two
          if (swap_q) begin
            state_q <= START;
          end
        end
        default: begin
          state_q <= START;
          busy_q  <= 1'b0;
        end
      endcase

      if (swap_d) begin
        active_q <= ~active_q;
        swap_q   <= 1'b1;
        if (swap_cnt_q == CNT_W'(MOVE_DIV - 1)) begin
          swap_cnt_q  <= '0;
          move_tick_q <= 1'b1;
        end else begin
          swap_cnt_q <= swap_cnt_q + CNT_W'(1);
        end
      end

      if (drop_inc_d && !(&drop_q)) begin
        drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  assign sched.active_frame = active_q;
  assign sched.draw_start   = draw_start_q;
  assign sched.swap         = swap_q;
  assign sched.move_tick    = move_tick_q;
  assign sched.busy         = busy_q;
  assign sched.drop_count   = drop_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - directed self-checking bench for frame_scheduler
module tb_frame_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic refresh = 1'b0;
  logic draw_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_scheduler_if #(.DROP_W(8)) m_if ();
  frame_scheduler_if #(.DROP_W(2)) s_if ();

  assign m_if.refresh   = refresh;
  assign m_if.draw_done = draw_done;
  assign s_if.refresh   = refresh;
  assign s_if.draw_done = draw_done;

  frame_scheduler #(.MOVE_DIV(3), .DROP_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (m_if.slave)
  );

  frame_scheduler #(.MOVE_DIV(1), .DROP_W(2)) dut_sat (
    .clk   (clk),
    .rst   (rst),
    .sched (s_if.slave)
  );

  typedef struct {
    logic       refresh;
    logic       draw_done;
    logic [4:0] exp_flags;  // {active_frame, draw_start, swap, move_tick, busy}
    int         exp_drop;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {m_if.active_frame, m_if.draw_start, m_if.swap, m_if.move_tick, m_if.busy};
  endfunction

  // Leaves the bench at the negedge inside cycle 1 (first cycle after release).
  task automatic do_reset();
    refresh   = 1'b0;
    draw_done = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int to_seen;

    tbl[0]  = '{1'b0, 1'b0, 5'b00000, 0};
    tbl[1]  = '{1'b0, 1'b1, 5'b01001, 0};
    tbl[2]  = '{1'b1, 1'b0, 5'b00001, 0};
    tbl[3]  = '{1'b0, 1'b1, 5'b00001, 1};
    tbl[4]  = '{1'b0, 1'b1, 5'b00000, 1};
    tbl[5]  = '{1'b1, 1'b0, 5'b00000, 1};
    tbl[6]  = '{1'b0, 1'b0, 5'b10100, 1};
    tbl[7]  = '{1'b0, 1'b0, 5'b10000, 1};
    tbl[8]  = '{1'b0, 1'b0, 5'b11001, 1};
    tbl[9]  = '{1'b1, 1'b1, 5'b10001, 1};
    tbl[10] = '{1'b0, 1'b0, 5'b00100, 1};
    tbl[11] = '{1'b0, 1'b0, 5'b00000, 1};
    tbl[12] = '{1'b0, 1'b0, 5'b01001, 1};
    tbl[13] = '{1'b0, 1'b1, 5'b00001, 1};
    tbl[14] = '{1'b1, 1'b0, 5'b00000, 1};
    tbl[15] = '{1'b0, 1'b0, 5'b10110, 1};
    tbl[16] = '{1'b0, 1'b0, 5'b10000, 1};
    tbl[17] = '{1'b0, 1'b0, 5'b11001, 1};

    // table: ignored done on draw_start, drop, HOLD-ignored done, coincident done+refresh, tick on 3rd swap
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("tbl%0d_flags", k + 1), int'(flags()), int'(tbl[k].exp_flags));
      chk($sformatf("tbl%0d_drop", k + 1), int'(m_if.drop_count), tbl[k].exp_drop);
      chk($sformatf("tbl%0d_tick_div1", k + 1), int'(s_if.move_tick), int'(tbl[k].exp_flags[2]));
      refresh   = tbl[k].refresh;
      draw_done = tbl[k].draw_done;
    end

    // reference timeline: done at 10, refresh at 20
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("ref_c%0d_draw_start", c), int'(m_if.draw_start), int'(c == 2 || c == 23));
      chk($sformatf("ref_c%0d_swap", c), int'(m_if.swap), int'(c == 21));
      chk($sformatf("ref_c%0d_active", c), int'(m_if.active_frame), int'(c >= 21));
      draw_done = (c == 10);
      refresh   = (c == 20);
    end

    // drops with saturation, then asynchronous reset mid-draw
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 13) begin
        chk("drop_after3", int'(m_if.drop_count), 3);
        chk("drop3_active", int'(m_if.active_frame), 1);
        chk("drop3_busy", int'(m_if.busy), 1);
        chk("drop3_swap", int'(m_if.swap), 0);
      end
      draw_done = (c == 4);
      refresh   = (c == 6) || (c >= 10);
    end
    @(negedge clk);
    refresh = 1'b0;
    chk("drop_after5", int'(m_if.drop_count), 5);
    chk("drop_sat_w2", int'(s_if.drop_count), 3);
    chk("drop5_busy", int'(m_if.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({flags(), m_if.drop_count, m_if.timeout_err}), 0);
    chk("async_rst_sat_drop", int'(s_if.drop_count), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_c1_draw_start", int'(m_if.draw_start), 0);
    @(negedge clk);
    chk("post_rst_c2_draw_start", int'(m_if.draw_start), 1);
    chk("post_rst_c2_active", int'(m_if.active_frame), 0);

    do_reset();
`ifdef FRAME_SCHED_TIMEOUT_EN
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("to_c%0d_err", c), int'(m_if.timeout_err), int'(c >= 18));
      chk($sformatf("to_c%0d_drop", c), int'(m_if.drop_count), int'(c >= 18));
      chk($sformatf("to_c%0d_draw_start", c), int'(m_if.draw_start), int'(c == 2 || c == 19));
    end
`else
    to_seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m_if.timeout_err !== 1'b0) to_seen++;
    end
    chk("no_timeout_1000", to_seen, 0);
    chk("draw_waits_busy", int'(m_if.busy), 1);
    chk("draw_waits_drop", int'(m_if.drop_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter MOVE_DIV, default 2: number of frame swaps per move_tick pulse, legal range 1..255.
REQ-002 Parameter DROP_W, default 8: width of drop_count.
REQ-003 Parameter TIMEOUT_CYCLES, default 420000: maximum draw duration in clk cycles, used only under REQ-024.
REQ-004 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 refresh  input  1  one-cycle pulse at the start of vertical blanking.
REQ-007 draw_done  input  1  one-cycle pulse from the frame writer when the back frame is complete.
REQ-008 active_frame  output  1  frame being scanned out (0 = frame_a, 1 = frame_b).
REQ-009 draw_start  output  1  one-cycle command to the writer to begin updating the back frame (~active_frame).
REQ-010 swap  output  1  one-cycle pulse in the cycle active_frame changes value.
REQ-011 move_tick  output  1  one-cycle player-movement enable, aligned with swap.
REQ-012 busy  output  1  high while a draw is outstanding.
REQ-013 drop_count  output  DROP_W  saturating count of refresh pulses that found no completed draw.
REQ-014 timeout_err  output  1  sticky draw-timeout flag.

Function
REQ-015 FSM states: START, DRAW, HOLD. All outputs are registered.
REQ-016 START: set draw_start for the next cycle, go to DRAW; START lasts exactly one cycle.
REQ-017 DRAW: busy=1; draw_done is ignored in the cycle draw_start is high; on draw_done go to HOLD.
REQ-018 DRAW + refresh without draw_done: drop_count += 1, saturating at all-ones; no swap; remain in DRAW.
REQ-019 DRAW + refresh and draw_done in the same cycle: treated as completed; swap behaviour is the same as REQ-020 in that cycle; no drop.
REQ-020 HOLD: busy=0; on refresh, toggle active_frame, pulse swap, go to START. New draw_start follows swap by 2 cycles.
REQ-021 HOLD + draw_done: ignored.
REQ-022 Swap counter 0..MOVE_DIV-1 increments on each swap and wraps to 0. move_tick is asserted with the swap that wraps the counter, so with MOVE_DIV=1 every swap ticks.
REQ-023 draw_start, swap and move_tick are never high for two consecutive cycles.

Configuration
REQ-024 Macro FRAME_SCHED_TIMEOUT_EN.
- Defined: a cycle counter runs in DRAW. Reaching TIMEOUT_CYCLES without draw_done sets timeout_err, increments drop_count (saturating), and returns the FSM to START to redraw the same back frame. The counter clears on entering DRAW.
- Undefined: no counter is built, timeout_err is constant 0, and DRAW waits indefinitely.

Reset
REQ-025 rst asserted at any time, including mid-draw: state=START, active_frame=0, draw_start=0, swap=0, move_tick=0, busy=0, drop_count=0, timeout_err=0, swap counter=0, timeout counter=0.
REQ-026 First cycle after rst deasserts: START. draw_start is high in the second cycle and targets frame_b.

Verification
REQ-027 Release rst, pulse draw_done at cycle 10, pulse refresh at cycle 20 -> draw_start high at cycle 2; swap high and active_frame=1 from cycle 21; next draw_start at cycle 23.
REQ-028 Refresh three times with no draw_done -> drop_count=3, active_frame unchanged, busy=1. With DROP_W=2 and 5 refreshes -> drop_count=3 (saturated).
REQ-029 draw_done and refresh in the same cycle while in DRAW -> swap next cycle, drop_count unchanged.
REQ-030 MOVE_DIV=3, 7 complete draw/refresh rounds -> move_tick on swaps 3 and 6 only.
REQ-031 Assert rst while in DRAW with active_frame=1, drop_count=5 -> all outputs 0 immediately (asynchronous); draw_start returns 2 cycles after release.
REQ-032 FRAME_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no draw_done -> timeout_err=1 and drop_count=1 after 16 DRAW cycles, then a new draw_start. Macro undefined -> timeout_err stays 0 for 1000 cycles.
